// File: rtl/gbcam_dither_capture.sv
// rtl/gbcam_dither_capture.sv - camera capture engine: 4x4 ordered dither of a 128x112 luma frame into GB 2bpp tiles
module gbcam_dither_capture (
   input  logic        sys_clock,
   input  logic        sys_reset,
   input  logic        Cam_Capture,
   input  logic        Bram_Req_Write,
   input  logic [9:0]  Bram_Addr,
   input  logic [7:0]  Bram_Data,
   output logic        Frame_req,
   input  logic        Pix_valid,
   input  logic [7:0]  Pix_data,
   output logic        Pix_ready,
   output logic        Sram_we,
   output logic [12:0] Sram_addr,
   output logic [7:0]  Sram_wdata,
   output logic        Sig_CamCaptureFinish
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_REQ     = 3'd1,
      S_CAPTURE = 3'd2,
      S_WR_HI   = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic        cap_prev_q, cap_prev_d;
   logic        breq_prev_q, breq_prev_d;
   logic [7:0]  thr_q [48];
   logic [7:0]  thr_d [48];
   logic [6:0]  x_q, x_d;
   logic [6:0]  y_q, y_d;
   logic [7:0]  lo_acc_q, lo_acc_d;
   logic [7:0]  hi_acc_q, hi_acc_d;
   logic        last_q, last_d;
   logic        we_q, we_d;
   logic [12:0] addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        fin_q, fin_d;

   logic        thr_wr;
   logic        pix_acc;
   logic [3:0]  mtx_idx;
   logic [5:0]  t_idx;
   logic [7:0]  t0, t1, t2;
   logic [1:0]  color;
   logic [7:0]  lo_new, hi_new;

   // Threshold write on the rising edge of the request, only inside the 48-entry window
   always_comb begin
      thr_wr = Bram_Req_Write && !breq_prev_q
               && (Bram_Addr[9:6] == 4'b1000) && (Bram_Addr[5:0] < 6'd48);
      thr_d = thr_q;
      if (thr_wr) begin
         thr_d[Bram_Addr[5:0]] = Bram_Data;
      end
   end

   // Classify the current pixel against its matrix cell and merge it into both plane bytes
   always_comb begin
      pix_acc = (state_q == S_CAPTURE) && Cam_Capture && Pix_valid;
      mtx_idx = {y_q[1:0], x_q[1:0]};
      t_idx   = {2'b00, mtx_idx} + {1'b0, mtx_idx, 1'b0};
      t0      = thr_q[t_idx];
      t1      = thr_q[t_idx + 6'd1];
      t2      = thr_q[t_idx + 6'd2];
      if (Pix_data < t0) begin
         color = 2'd3;
      end else if (Pix_data < t1) begin
         color = 2'd2;
      end else if (Pix_data < t2) begin
         color = 2'd1;
      end else begin
         color = 2'd0;
      end
      lo_new = lo_acc_q;
      hi_new = hi_acc_q;
      lo_new[~x_q[2:0]] = color[0];
      hi_new[~x_q[2:0]] = color[1];
   end

   // Next-state logic; a low trigger aborts any in-progress capture
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (Cam_Capture && !cap_prev_q) begin
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            state_d = Cam_Capture ? S_CAPTURE : S_IDLE;
         end
         S_CAPTURE: begin
            if (!Cam_Capture) begin
               state_d = S_IDLE;
            end else if (pix_acc && (x_q[2:0] == 3'd7)) begin
               state_d = S_WR_HI;
            end
         end
         S_WR_HI: begin
            if (!Cam_Capture) begin
               state_d = S_IDLE;
            end else if (last_q) begin
               state_d = S_DONE;
            end else begin
               state_d = S_CAPTURE;
            end
         end
         S_DONE: begin
            if (!Cam_Capture) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Position counters, accumulators and the registered SRAM write port
   always_comb begin
      cap_prev_d  = Cam_Capture;
      breq_prev_d = Bram_Req_Write;
      x_d         = x_q;
      y_d         = y_q;
      lo_acc_d    = lo_acc_q;
      hi_acc_d    = hi_acc_q;
      last_d      = last_q;
      we_d        = 1'b0;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      fin_d       = (state_q == S_DONE) && Cam_Capture;
      if (state_q == S_REQ) begin
         x_d      = 7'd0;
         y_d      = 7'd0;
         lo_acc_d = 8'd0;
         hi_acc_d = 8'd0;
         last_d   = 1'b0;
      end
      if (pix_acc) begin
         lo_acc_d = lo_new;
         hi_acc_d = hi_new;
         x_d      = x_q + 7'd1;
         if (x_q == 7'd127) begin
            y_d = y_q + 7'd1;
         end
         if (x_q[2:0] == 3'd7) begin
            we_d    = 1'b1;
            addr_d  = 13'h100 + {1'b0, y_q[6:3], x_q[6:3], y_q[2:0], 1'b0};
            wdata_d = lo_new;
            last_d  = (x_q == 7'd127) && (y_q == 7'd111);
         end
      end
      if ((state_q == S_WR_HI) && Cam_Capture) begin
         we_d    = 1'b1;
         addr_d  = addr_q | 13'd1;
         wdata_d = hi_acc_q;
      end
   end

   // Moore outputs decoded from the current state
   always_comb begin
      Frame_req            = (state_q == S_REQ);
      Pix_ready            = (state_q == S_CAPTURE);
      Sram_we              = we_q;
      Sram_addr            = addr_q;
      Sram_wdata           = wdata_q;
      Sig_CamCaptureFinish = fin_q;
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge sys_clock) begin
      if (sys_reset) begin
         state_q     <= S_IDLE;
         cap_prev_q  <= 1'b0;
         breq_prev_q <= 1'b0;
         x_q         <= 7'd0;
         y_q         <= 7'd0;
         lo_acc_q    <= 8'd0;
         hi_acc_q    <= 8'd0;
         last_q      <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= 13'd0;
         wdata_q     <= 8'd0;
         fin_q       <= 1'b0;
         for (int i = 0; i < 48; i++) begin
            thr_q[i] <= 8'd0;
         end
      end else begin
         state_q     <= state_d;
         cap_prev_q  <= cap_prev_d;
         breq_prev_q <= breq_prev_d;
         x_q         <= x_d;
         y_q         <= y_d;
         lo_acc_q    <= lo_acc_d;
         hi_acc_q    <= hi_acc_d;
         last_q      <= last_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         fin_q       <= fin_d;
         thr_q       <= thr_d;
      end
   end

endmodule
